// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads instruction memory and hands
// {pc, instr} pairs to the processor through a 2-entry valid/ready buffer.
// Redirects flush the buffer and restart fetch at the (word-aligned) target.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_en,
  output logic [31:0] inst_addr,
  input  logic [31:0] instr,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] issue_count,
  output logic        misaligned
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 2;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  logic [XLEN-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  entry_t           slot0_q, slot0_d;
  entry_t           slot1_q, slot1_d;
  logic [XLEN-1:0]  issue_q, issue_d;
  logic             mis_q, mis_d;

  logic   pop_c;
  logic   fetch_c;
  entry_t new_entry_c;

  // Handshake and fetch qualification for this cycle
  always_comb begin
    pop_c             = (cnt_q != '0) & out_ready;
    fetch_c           = fetch_en & ~redirect & ((cnt_q < CNT_W'(2)) | pop_c);
    new_entry_c.pc    = pc_q;
    new_entry_c.instr = instr;
  end

  // Next-state: slot0 is always the head; unused slots are kept at zero so the
  // head outputs read zero when the buffer is empty
  always_comb begin
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    issue_d = issue_q + XLEN'(pop_c);
    mis_d   = mis_q;

    if (redirect) begin
      cnt_d   = '0;
      slot0_d = '0;
      slot1_d = '0;
      pc_d    = {redirect_pc[XLEN-1:2], 2'b00};
      mis_d   = mis_q | (redirect_pc[1:0] != 2'b00);
    end else begin
      if (fetch_c) begin
        pc_d = pc_q + XLEN'(PC_STEP);
      end
      case ({pop_c, fetch_c})
        2'b10: begin
          slot0_d = slot1_q;
          slot1_d = '0;
          cnt_d   = cnt_q - CNT_W'(1);
        end
        2'b01: begin
          if (cnt_q == '0) begin
            slot0_d = new_entry_c;
          end else begin
            slot1_d = new_entry_c;
          end
          cnt_d = cnt_q + CNT_W'(1);
        end
        2'b11: begin
          // Pop frees a slot first, so occupancy is unchanged
          if (cnt_q == CNT_W'(2)) begin
            slot0_d = slot1_q;
            slot1_d = new_entry_c;
          end else begin
            slot0_d = new_entry_c;
          end
        end
        default: ;
      endcase
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
      slot0_q <= '0;
      slot1_q <= '0;
      issue_q <= '0;
      mis_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      issue_q <= issue_d;
      mis_q   <= mis_d;
    end
  end

  // Outputs straight from state
  always_comb begin
    inst_addr   = pc_q;
    out_valid   = (cnt_q != '0);
    out_instr   = slot0_q.instr;
    out_pc      = slot0_q.pc;
    issue_count = issue_q;
    misaligned  = mis_q;
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: expected {pc, instr} pairs are queued
// as fetches are driven and compared as the DUT hands them out.
module tb_instr_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_en;
  logic [31:0] inst_addr;
  logic [31:0] instr;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] issue_count;
  logic        misaligned;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_issue;
  logic        m_mis;

  instr_fetch_unit #(.RESET_PC(RST_PC), .PC_STEP(4)) dut (
    .clk(clk), .reset(reset), .fetch_en(fetch_en), .inst_addr(inst_addr),
    .instr(instr), .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .issue_count(issue_count), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  // Instruction memory model
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h100: return 32'h11;
      32'h104: return 32'h22;
      32'h108: return 32'h33;
      default: return a ^ 32'hA5A5_0000;
    endcase
  endfunction

  assign instr = mem_word(inst_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic model_reset();
    sb_q.delete();
    m_pc    = RST_PC;
    m_issue = '0;
    m_mis   = 1'b0;
  endtask

  // One clock: inputs already driven (at negedge); checks head, predicts, steps
  task automatic step();
    logic pop;
    exp_t e;
    check("out_valid", 32'(out_valid), 32'(sb_q.size() != 0));
    pop = out_valid && out_ready;
    if (sb_q.size() == 0) begin
      check("empty_pc", out_pc, 32'h0);
      check("empty_instr", out_instr, 32'h0);
    end else begin
      check("head_pc", out_pc, sb_q[0].pc);
      check("head_instr", out_instr, sb_q[0].word);
    end
    if (pop && sb_q.size() != 0) begin
      void'(sb_q.pop_front());
      m_issue = m_issue + 32'd1;
    end
    if (redirect) begin
      sb_q.delete();
      m_pc  = {redirect_pc[31:2], 2'b00};
      m_mis = m_mis | (redirect_pc[1:0] != 2'b00);
    end else if (fetch_en && (sb_q.size() < 2 || pop)) begin
      e.pc   = m_pc;
      e.word = mem_word(m_pc);
      sb_q.push_back(e);
      m_pc = m_pc + 32'd4;
    end
    @(posedge clk);
    @(negedge clk);
    check("inst_addr", inst_addr, m_pc);
    check("issue_count", issue_count, m_issue);
    check("misaligned", 32'(misaligned), 32'(m_mis));
  endtask

  task automatic drive(input logic fe, input logic rdy, input logic rd, input logic [31:0] rpc);
    fetch_en    = fe;
    out_ready   = rdy;
    redirect    = rd;
    redirect_pc = rpc;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_inst_addr", inst_addr, RST_PC);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_out_instr", out_instr, 32'h0);
    check("rst_issue", issue_count, 32'h0);
    check("rst_mis", 32'(misaligned), 32'h0);
    reset = 1'b0;

    // Streaming from reset: 0x100/0x11, 0x104/0x22, 0x108/0x33
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    step();
    check("first_pc", out_pc, 32'h100);
    check("first_instr", out_instr, 32'h11);
    repeat (2) step();
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    step();
    check("issue_after3", issue_count, 32'd3);

    // Backpressure from empty at 0x100
    drive(1'b0, 1'b0, 1'b1, 32'h100);
    step();
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    repeat (4) step();
    check("bp_freeze_addr", inst_addr, 32'h108);
    check("bp_head_pc", out_pc, 32'h100);
    check("bp_head_instr", out_instr, 32'h11);
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    repeat (3) step();

    // Redirect while popping a full buffer
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    repeat (2) step();
    check("full_before_redir", 32'(sb_q.size()), 32'd2);
    drive(1'b1, 1'b1, 1'b1, 32'h400);
    step();
    check("redir_valid0", 32'(out_valid), 32'h0);
    check("redir_addr", inst_addr, 32'h400);
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    step();
    check("redir_head_pc", out_pc, 32'h400);

    // Misaligned redirect: flag is sticky
    drive(1'b1, 1'b1, 1'b1, 32'h403);
    step();
    check("mis_addr", inst_addr, 32'h400);
    check("mis_set", 32'(misaligned), 32'h1);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'($urandom_range(0, 1)), 1'b0, 32'h0);
      step();
    end

    // PC wrap
    drive(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
    step();
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    step();
    check("wrap_pc0", out_pc, 32'hFFFF_FFFC);
    step();
    check("wrap_pc1", out_pc, 32'h0000_0000);
    step();
    check("wrap_pc2", out_pc, 32'h0000_0004);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 9) == 0), $urandom);
      step();
    end

    // Asynchronous reset between edges with a valid head
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    step();
    step();
    check("pre_rst_valid", 32'(out_valid), 32'h1);
    #2 reset = 1'b1;
    #1;
    check("arst_valid", 32'(out_valid), 32'h0);
    check("arst_issue", issue_count, 32'h0);
    check("arst_addr", inst_addr, RST_PC);
    check("arst_mis", 32'(misaligned), 32'h0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    repeat (4) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction-fetch stage upstream of `Processor`. Holds the program counter, drives the instruction address into `Memory`, and captures the returned word. It hands each (PC, instruction) pair to the processor through a 2-entry valid/ready buffer. Branch and jump redirects from the processor flush the buffer and restart fetch at the target address.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset; must be word-aligned.
- `PC_STEP`, default 4: PC increment per fetched word.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately, independent of `clk`.
- `fetch_en`  in  1  when low, no new fetches; buffer still drains.
- `inst_addr`  out  32  address to `Memory.inst_addr`; equals the PC register.
- `instr`  in  32  word from `Memory.instr`; combinational, valid in the same cycle as `inst_addr`.
- `redirect`  in  1  one-cycle request to restart fetch at `redirect_pc`.
- `redirect_pc`  in  32  target address, sampled when `redirect`=1.
- `out_valid`  out  1  buffer head holds a valid entry.
- `out_ready`  in  1  processor accepts the head this cycle.
- `out_instr`  out  32  head instruction.
- `out_pc`  out  32  address of the head instruction.
- `issue_count`  out  32  number of completed handshakes since reset.
- `misaligned`  out  1  sticky flag, set when a redirect target has nonzero bits [1:0].

## Operation
Definitions:
- pop = `out_valid` & `out_ready`.
- fetch = `fetch_en` & !`redirect` & (count < 2 | pop).
- Buffer: 2-entry FIFO of {pc, instr}; count is 0..2.

Each edge, in priority order:
- `reset`: pc=`RESET_PC`, count=0, buffer contents=0, `issue_count`=0, `misaligned`=0.
- `redirect`:
  - If pop, `issue_count` increments.
  - Buffer flushed; count=0.
  - pc = {`redirect_pc`[31:2], 2'b00}.
  - If `redirect_pc`[1:0] != 0, `misaligned` is set.
  - No push this cycle.
- Otherwise, pop and push act independently:
  - pop: the head is removed and `issue_count` increments.
  - fetch: {pc, `instr`} is pushed at the tail and pc increments by `PC_STEP`.
  - Simultaneous pop and push at count=2 leaves count=2 (pop frees a slot first).

Output and arithmetic rules:
- `out_valid` = (count != 0). `out_instr` and `out_pc` are driven from the head entry; they read 0 when the buffer is empty.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- `issue_count` wraps 32'hFFFF_FFFF -> 0.
- `misaligned` clears only on reset.
- Head stability: while `out_valid`=1 and `out_ready`=0, `out_instr` and `out_pc` must not change unless `redirect` or `reset` is asserted.

## Timing
- Reset values: `inst_addr`=`RESET_PC`, `out_valid`=0, `out_instr`=0, `out_pc`=0, `issue_count`=0, `misaligned`=0.
- Fetch latency:
  - Word fetched at edge N appears at the head on cycle N+1 if the buffer was empty.
  - After reset deassert with `fetch_en`=1, `out_valid` rises after the first edge, with `out_pc`=`RESET_PC`.
- Redirect:
  - `redirect` sampled at edge N; `inst_addr`=target during cycle N+1.
  - `out_valid`=1 with `out_pc`=target after edge N+1.
  - This is a 1-cycle bubble.
- Throughput:
  - 1 instruction per cycle with `out_ready` held high.
  - With `out_ready`=0 the buffer fills in 2 cycles; fetch then stops and pc holds.
- `fetch_en` low: pc holds and no push occurs. `inst_addr` still shows pc.
- Reset mid-operation: outputs take reset values asynchronously, without waiting for `clk`; any in-flight handshake is discarded.

## Test plan
- Reset: `RESET_PC`=0x100, `fetch_en`=1, `out_ready`=1; memory returns 0x11,0x22,0x33 at 0x100/0x104/0x108.
  - Required: `out_pc`/`out_instr` = 0x100/0x11, 0x104/0x22, 0x108/0x33 on consecutive cycles; `issue_count`=3 after.
- Backpressure: hold `out_ready`=0 for 4 cycles from empty.
  - Required: count reaches 2 and `inst_addr` freezes at 0x108; head stays 0x100/0x11.
  - Release `out_ready`: 0x100, 0x104, 0x108 delivered in order with no duplicates or drops.
- Redirect with pop: buffer holds 2 entries, `redirect`=1 with `redirect_pc`=0x400 and `out_ready`=1.
  - Required: `issue_count` +1; next cycle `out_valid`=0 and `inst_addr`=0x400; following cycle `out_pc`=0x400.
- Misaligned redirect: `redirect_pc`=0x403.
  - Required: next fetch at 0x400 and `misaligned`=1; the flag persists through 10 further cycles and clears only on reset.
- Wrap: redirect to 0xFFFF_FFFC.
  - Required: `out_pc` sequence 0xFFFF_FFFC, 0x0000_0000, 0x0000_0004.
- Async reset mid-stream: assert `reset` between edges while `out_valid`=1.
  - Required: `out_valid`=0, `issue_count`=0 and `inst_addr`=`RESET_PC` before the next `clk` edge.
